// File: rtl/wishbone_cmd_deframer.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_cmd_deframer
// Brief    : Assembles header + 4 payload bytes into a 34-bit command word
//            for wishbone_master; flags bad headers, timeouts and overruns.
// Revision : 1.0  initial release
// ============================================================================
module wishbone_cmd_deframer #(
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter logic [3:0] SYNC_NIBBLE    = 4'hA
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_rx_stb,
    input  logic [7:0]  i_rx_byte,
    output logic        o_rx_busy,
    output logic        o_cmd_stb,
    output logic [33:0] o_cmd_word,
    input  logic        i_cmd_busy,
    output logic        o_frame_err,
    output logic        o_overflow,
    output logic [7:0]  o_err_count
);

    localparam int                  c_TIMER_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_DATA = 2'd1;
    localparam logic [1:0] c_S_OUT  = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           r_cnt;
    logic [c_TIMER_W-1:0] r_timer;
    logic [1:0]           r_type;
    logic [23:0]          r_payload;
    logic [33:0]          r_cmd_word;
    logic                 r_frame_err;
    logic                 r_overflow;
    logic [7:0]           r_err_count;

    logic                 w_hdr_ok;
    logic [1:0]           w_err_inc;
    logic [8:0]           w_err_sum;
    logic [7:0]           w_err_count_next;

    assign w_hdr_ok = (i_rx_byte[7:4] == SYNC_NIBBLE) && (i_rx_byte[3:2] == 2'b00);

    // Both pulse sources can be added in one cycle; the sum saturates at 8'hFF.
    assign w_err_inc        = {1'b0, r_frame_err} + {1'b0, r_overflow};
    assign w_err_sum        = {1'b0, r_err_count} + {7'd0, w_err_inc};
    assign w_err_count_next = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= 2'd0;
            r_timer     <= '0;
            r_type      <= 2'd0;
            r_payload   <= 24'd0;
            r_cmd_word  <= 34'd0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
            r_err_count <= w_err_count_next;
            case (r_state)
                c_S_IDLE: begin
                    if (i_rx_stb) begin
                        if (w_hdr_ok) begin
                            r_type  <= i_rx_byte[1:0];
                            r_cnt   <= 2'd0;
                            r_timer <= '0;
                            r_state <= c_S_DATA;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                c_S_DATA: begin
                    if (i_rx_stb) begin
                        r_payload <= {r_payload[15:0], i_rx_byte};
                        r_timer   <= '0;
                        r_cnt     <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_cmd_word <= {r_type, r_payload, i_rx_byte};
                            r_state    <= c_S_OUT;
                        end
                    end else if (r_timer == c_TIMEOUT_LAST) begin
                        r_frame_err <= 1'b1;
                        r_state     <= c_S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_S_OUT: begin
                    // Any byte offered here is lost, including on the accept cycle.
                    if (i_rx_stb) r_overflow <= 1'b1;
                    if (!i_cmd_busy) r_state <= c_S_IDLE;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign o_rx_busy   = (r_state == c_S_OUT);
    assign o_cmd_stb   = (r_state == c_S_OUT);
    assign o_cmd_word  = r_cmd_word;
    assign o_frame_err = r_frame_err;
    assign o_overflow  = r_overflow;
    assign o_err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_cmd_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wishbone_cmd_deframer
// Brief    : Directed self-checking bench for wishbone_cmd_deframer.
// Revision : 1.0  initial release
// ============================================================================
module tb_wishbone_cmd_deframer;

    localparam int c_TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_rx_stb;
    logic [7:0]  i_rx_byte;
    logic        o_rx_busy;
    logic        o_cmd_stb;
    logic [33:0] o_cmd_word;
    logic        i_cmd_busy;
    logic        o_frame_err;
    logic        o_overflow;
    logic [7:0]  o_err_count;

    int errors = 0;
    int checks = 0;

    wishbone_cmd_deframer #(
        .TIMEOUT_CYCLES (c_TIMEOUT),
        .SYNC_NIBBLE    (4'hA)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (i_reset_n),
        .i_rx_stb    (i_rx_stb),
        .i_rx_byte   (i_rx_byte),
        .o_rx_busy   (o_rx_busy),
        .o_cmd_stb   (o_cmd_stb),
        .o_cmd_word  (o_cmd_word),
        .i_cmd_busy  (i_cmd_busy),
        .o_frame_err (o_frame_err),
        .o_overflow  (o_overflow),
        .o_err_count (o_err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_stb  = 1'b1;
        i_rx_byte = b;
        step();
        i_rx_stb  = 1'b0;
        i_rx_byte = 8'h00;
    endtask

    initial begin
        logic bad;
        i_reset_n  = 1'b0;
        i_rx_stb   = 1'b0;
        i_rx_byte  = 8'h00;
        i_cmd_busy = 1'b0;
        step();
        step();
        chk("reset_stb", 34'(o_cmd_stb), 34'd0);
        chk("reset_busy", 34'(o_rx_busy), 34'd0);
        chk("reset_word", o_cmd_word, 34'd0);
        chk("reset_errcnt", 34'(o_err_count), 34'd0);
        i_reset_n = 1'b1;
        step();

        // 1: basic frame with downstream stall of 3 cycles
        i_cmd_busy = 1'b1;
        send_byte(8'hA1); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        chk("t1_stb_early", 34'(o_cmd_stb), 34'd0);
        send_byte(8'hEF);
        chk("t1_stb_rise", 34'(o_cmd_stb), 34'd1);
        chk("t1_rx_busy", 34'(o_rx_busy), 34'd1);
        chk("t1_word", o_cmd_word, 34'h1_DEADBEEF);
        step(); step(); step();
        chk("t1_stb_held", 34'(o_cmd_stb), 34'd1);
        i_cmd_busy = 1'b0;
        step();
        chk("t1_stb_drop", 34'(o_cmd_stb), 34'd0);
        chk("t1_word_hold", o_cmd_word, 34'h1_DEADBEEF);

        // 2: bad header then a good frame
        send_byte(8'h51);
        chk("t2_ferr_pulse", 34'(o_frame_err), 34'd1);
        step();
        chk("t2_ferr_low", 34'(o_frame_err), 34'd0);
        chk("t2_errcnt", 34'(o_err_count), 34'd1);
        send_byte(8'hA0); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
        chk("t2_stb", 34'(o_cmd_stb), 34'd1);
        chk("t2_word", o_cmd_word, 34'h0_00000004);
        step();
        chk("t2_accept", 34'(o_cmd_stb), 34'd0);

        // 3: timeout after partial frame
        send_byte(8'hA2); send_byte(8'h11); send_byte(8'h22);
        bad = 1'b0;
        for (int i = 1; i < c_TIMEOUT; i++) begin
            step();
            if (o_frame_err || o_cmd_stb) bad = 1'b1;
        end
        chk("t3_no_early_ferr", 34'(bad), 34'd0);
        step();
        chk("t3_ferr_at_timeout", 34'(o_frame_err), 34'd1);
        chk("t3_no_stb", 34'(o_cmd_stb), 34'd0);
        step();
        chk("t3_errcnt", 34'(o_err_count), 34'd2);
        send_byte(8'hA3); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("t3_word", o_cmd_word, 34'h3_01020304);
        chk("t3_stb", 34'(o_cmd_stb), 34'd1);
        step();

        // 4: overrun while stalled and on the accept cycle
        i_cmd_busy = 1'b1;
        send_byte(8'hA1); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        chk("t4_word", o_cmd_word, 34'h1_00000002);
        send_byte(8'h55);
        chk("t4_ovf_pulse", 34'(o_overflow), 34'd1);
        chk("t4_word_kept", o_cmd_word, 34'h1_00000002);
        chk("t4_stb_held", 34'(o_cmd_stb), 34'd1);
        step();
        chk("t4_ovf_low", 34'(o_overflow), 34'd0);
        chk("t4_errcnt", 34'(o_err_count), 34'd3);
        i_cmd_busy = 1'b0;
        send_byte(8'h55);
        chk("t4_accept_ovf", 34'(o_overflow), 34'd1);
        chk("t4_accept_drop", 34'(o_cmd_stb), 34'd0);
        step();
        chk("t4_errcnt2", 34'(o_err_count), 34'd4);
        send_byte(8'hA2); send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
        chk("t4_next_word", o_cmd_word, 34'h2_CAFEBABE);
        step();

        // 5: asynchronous reset mid-frame
        send_byte(8'hA1); send_byte(8'h11); send_byte(8'h22);
        i_reset_n = 1'b0;
        #1;
        chk("t5_rst_word", o_cmd_word, 34'd0);
        chk("t5_rst_errcnt", 34'(o_err_count), 34'd0);
        chk("t5_rst_stb", 34'(o_cmd_stb), 34'd0);
        step();
        i_reset_n = 1'b1;
        step();
        send_byte(8'hA1); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("t5_no_stale_stb", 34'(o_cmd_stb), 34'd0);
        send_byte(8'h01);
        chk("t5_word", o_cmd_word, 34'h1_00000001);
        chk("t5_stb", 34'(o_cmd_stb), 34'd1);
        step();

        // 6: back-to-back frames, header on the cycle after accept
        send_byte(8'hA1); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        chk("t6_word1", o_cmd_word, 34'h1_AABBCCDD);
        step();
        chk("t6_stb_gap", 34'(o_cmd_stb), 34'd0);
        send_byte(8'hA2); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        chk("t6_stb2", 34'(o_cmd_stb), 34'd1);
        chk("t6_word2", o_cmd_word, 34'h2_12345678);
        step();
        step();
        chk("t6_errcnt", 34'(o_err_count), 34'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
